// File: rtl/seg_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seg_scan_ctrl_pkg
// Brief   : Shared types and constants for the seven-segment scan controller.
// Revision: 1.0  initial release
// ============================================================================
package seg_scan_ctrl_pkg;

    // Scan controller phases
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } scan_state_t;

    // Last digit position in a frame
    localparam logic [2:0] POS_LAST = 3'd7;

endpackage : seg_scan_ctrl_pkg
`default_nettype wire

// File: rtl/seg_scan_presc.sv
`default_nettype none
// ============================================================================
// Module  : seg_scan_presc
// Brief   : Terminal-count prescaler. Counts 0..limit and flags tc on the
//           last count, then wraps to 0. clr forces the count to 0.
// Revision: 1.0  initial release
// ============================================================================
module seg_scan_presc
    import seg_scan_ctrl_pkg::*;
#(
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);

    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;

    // tc marks the final cycle of the current phase
    assign tc = (r_cnt == limit);

    // Count up, restarting at 0 after the terminal count or on clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || tc) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_one;
        end
    end

endmodule : seg_scan_presc
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : seg_scan_ctrl
// Brief   : 8-digit time-multiplexed seven-segment scan controller with
//           per-digit enable, leading-zero suppression, blanking gaps and
//           tear-free value updates at frame boundaries.
// Revision: 1.0  initial release
// ============================================================================
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int GAP_CYC  = 1000,
    parameter int CNT_W    = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [31:0] value,
    input  logic        load,
    input  logic [7:0]  digit_en,
    input  logic        lz_en,
    output logic [3:0]  dig,
    output logic [2:0]  pos,
    output logic        blank,
    output logic        frame_done
);

    localparam logic [CNT_W-1:0] c_show_lim = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] c_gap_lim  = CNT_W'(GAP_CYC - 1);

    scan_state_t      r_state;
    logic [31:0]      r_pending;
    logic [31:0]      r_active;
    logic [3:0]       r_dig;
    logic [2:0]       r_pos;
    logic             r_blank;
    logic             r_frame_done;

    logic             w_tc;
    logic             w_presc_clr;
    logic [CNT_W-1:0] w_limit;
    logic             w_xfer;
    logic [31:0]      w_active_nxt;
    logic [2:0]       w_pos_nxt;
    logic [3:0]       w_dig_nxt;
    logic [7:0]       w_lz_mask;
    logic             w_slot_blank;

    // One prescaler times both phases; the limit follows the current phase
    assign w_presc_clr = (r_state == IDLE) || !enable;
    assign w_limit     = (r_state == GAP) ? c_gap_lim : c_show_lim;

    seg_scan_presc #(
        .CNT_W (CNT_W)
    ) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_presc_clr),
        .limit (w_limit),
        .tc    (w_tc)
    );

    // The displayed value is only replaced on IDLE exit or the 7->0 wrap,
    // so a frame never mixes two values.
    assign w_xfer       = enable && ((r_state == IDLE) ||
                          ((r_state == GAP) && w_tc && (r_pos == POS_LAST)));
    assign w_active_nxt = w_xfer ? r_pending : r_active;

    // Position for the next cycle; 3-bit increment wraps 7 back to 0
    assign w_pos_nxt = (r_state == IDLE)            ? 3'd0 :
                       ((r_state == GAP) && w_tc)   ? (r_pos + 3'd1) :
                                                      r_pos;

    // Outputs are registered, so slot content is computed from next-cycle
    // position and value.
    assign w_dig_nxt = w_active_nxt[{w_pos_nxt, 2'b00} +: 4];

    // Leading-zero mask: position k is a leading zero when every nibble from
    // k upward is zero. Position 0 is never suppressed.
    assign w_lz_mask[0] = 1'b0;
    for (genvar k = 1; k < 8; k++) begin : g_lz
        assign w_lz_mask[k] = (w_active_nxt[31:4*k] == '0);
    end

    assign w_slot_blank = ~digit_en[w_pos_nxt] | (lz_en & w_lz_mask[w_pos_nxt]);

    // Pending register captures every load strobe, independent of scanning
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else if (load) begin
            r_pending <= value;
        end
    end

    // Scan FSM with registered display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_active     <= '0;
            r_dig        <= '0;
            r_pos        <= '0;
            r_blank      <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (!enable) begin
                r_state <= IDLE;
                r_pos   <= '0;
                r_blank <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state  <= SHOW;
                        r_active <= w_active_nxt;
                        r_pos    <= w_pos_nxt;
                        r_dig    <= w_dig_nxt;
                        r_blank  <= w_slot_blank;
                    end
                    SHOW: begin
                        if (w_tc) begin
                            r_state <= GAP;
                            r_blank <= 1'b1;
                        end else begin
                            // digit_en / lz_en are live during the slot
                            r_dig   <= w_dig_nxt;
                            r_blank <= w_slot_blank;
                        end
                    end
                    GAP: begin
                        if (w_tc) begin
                            r_state  <= SHOW;
                            r_active <= w_active_nxt;
                            r_pos    <= w_pos_nxt;
                            r_dig    <= w_dig_nxt;
                            r_blank  <= w_slot_blank;
                            if (r_pos == POS_LAST) begin
                                r_frame_done <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_pos   <= '0;
                        r_blank <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign dig        = r_dig;
    assign pos        = r_pos;
    assign blank      = r_blank;
    assign frame_done = r_frame_done;

endmodule : seg_scan_ctrl
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg_scan_ctrl
// Brief   : Self-checking bench for seg_scan_ctrl. A frame-time reference
//           model predicts position, blanking, digit and frame pulse.
// Revision: 1.0  initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int SD    = 4;
    localparam int GC    = 2;
    localparam int SLOT  = SD + GC;
    localparam int FRAME = 8 * SLOT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [31:0] value;
    logic        load;
    logic [7:0]  digit_en;
    logic        lz_en;
    logic [3:0]  dig;
    logic [2:0]  pos;
    logic        blank;
    logic        frame_done;

    int errors = 0;
    int checks = 0;
    string phase = "reset";

    // Reference model state: time index inside the current frame
    bit          m_run;
    int          m_t;
    logic [31:0] m_pending;
    logic [31:0] m_active;
    logic [3:0]  e_dig;
    logic [2:0]  e_pos;
    logic        e_blank;
    logic        e_fd;

    seg_scan_ctrl #(
        .SCAN_DIV (SD),
        .GAP_CYC  (GC),
        .CNT_W    (17)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .value      (value),
        .load       (load),
        .digit_en   (digit_en),
        .lz_en      (lz_en),
        .dig        (dig),
        .pos        (pos),
        .blank      (blank),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Advance the model by one clock using the inputs present at the edge
    task automatic model_step();
        logic [31:0] old_p;
        int p;
        old_p = m_pending;
        if (load) m_pending = value;
        e_fd = 1'b0;
        if (!enable) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            m_run    = 1'b1;
            m_t      = 0;
            m_active = old_p;
        end else begin
            m_t++;
            if (m_t == FRAME) begin
                m_t      = 0;
                m_active = old_p;
                e_fd     = 1'b1;
            end
        end
        if (!m_run) begin
            e_pos   = 3'd0;
            e_blank = 1'b1;
        end else begin
            p     = m_t / SLOT;
            e_pos = 3'(p);
            e_dig = 4'(m_active >> (4 * p));
            if ((m_t % SLOT) >= SD)
                e_blank = 1'b1;
            else
                e_blank = !digit_en[p] || (lz_en && p != 0 && (m_active >> (4 * p)) == 32'd0);
        end
    endtask

    task automatic check_model();
        checks++;
        assert (pos === e_pos) else begin
            errors++;
            $error("FAIL %s pos got=%0d exp=%0d t=%0d", phase, pos, e_pos, m_t);
        end
        checks++;
        assert (blank === e_blank) else begin
            errors++;
            $error("FAIL %s blank got=%0b exp=%0b t=%0d", phase, blank, e_blank, m_t);
        end
        checks++;
        assert (frame_done === e_fd) else begin
            errors++;
            $error("FAIL %s frame_done got=%0b exp=%0b t=%0d", phase, frame_done, e_fd, m_t);
        end
        if (m_run) begin
            checks++;
            assert (dig === e_dig) else begin
                errors++;
                $error("FAIL %s dig got=%h exp=%h t=%0d", phase, dig, e_dig, m_t);
            end
        end
    endtask

    task automatic check_reset(input string tag);
        checks++;
        assert (dig === 4'd0) else begin
            errors++; $error("FAIL %s dig got=%h exp=0", tag, dig);
        end
        checks++;
        assert (pos === 3'd0) else begin
            errors++; $error("FAIL %s pos got=%0d exp=0", tag, pos);
        end
        checks++;
        assert (blank === 1'b1) else begin
            errors++; $error("FAIL %s blank got=%0b exp=1", tag, blank);
        end
        checks++;
        assert (frame_done === 1'b0) else begin
            errors++; $error("FAIL %s frame_done got=%0b exp=0", tag, frame_done);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    // Advance until the model sits at frame time index t (bounded)
    task automatic run_to(input int t);
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (m_run && m_t == t) break;
            cyc();
        end
    endtask

    task automatic pulse_load(input logic [31:0] v);
        value = v;
        load  = 1'b1;
        cyc();
        load  = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b0;
        load     = 1'b0;
        value    = '0;
        digit_en = 8'hFF;
        lz_en    = 1'b0;
        m_run     = 1'b0;
        m_t       = 0;
        m_pending = '0;
        m_active  = '0;
        e_dig = '0; e_pos = '0; e_blank = 1'b1; e_fd = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;

        // Basic scan: dig equals pos, 48-cycle frames
        phase = "scan";
        pulse_load(32'h7654_3210);
        enable = 1'b1;
        run(2 * FRAME + 4);

        // Leading-zero suppression
        phase = "lz";
        lz_en = 1'b1;
        pulse_load(32'h0000_A0F0);
        run(2 * FRAME);
        phase = "lz_zero";
        pulse_load(32'h0000_0000);
        run(2 * FRAME);

        // Per-digit enable mask keeps slot timing
        phase = "digit_en";
        lz_en    = 1'b0;
        digit_en = 8'b1010_0101;
        pulse_load(32'hFFFF_FFFF);
        run(2 * FRAME);

        // Tear-free update, including a load on the wrap edge
        phase = "tear";
        digit_en = 8'hFF;
        pulse_load(32'h2222_2222);
        run(2 * FRAME);
        run_to(20);
        pulse_load(32'h1111_1111);
        run_to(FRAME - 1);
        pulse_load(32'h3333_3333);
        run(2 * FRAME + 2);

        // Drop enable during position 5 SHOW, then restart
        phase = "disable";
        run_to(5 * SLOT + 1);
        enable = 1'b0;
        run(3);
        enable = 1'b1;
        run(FRAME + 6);

        // Asynchronous reset in the middle of a GAP phase
        phase = "async_rst";
        lz_en = 1'b1;
        run_to(SLOT + SD);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async_rst_immediate");
        m_run = 1'b0; m_t = 0; m_pending = '0; m_active = '0;
        e_dig = '0; e_pos = '0; e_blank = 1'b1; e_fd = 1'b0;
        @(posedge clk);
        #1;
        check_reset("async_rst_held");
        #2;
        rst_n = 1'b1;
        phase = "after_rst";
        run(FRAME + 6);

        // Randomized traffic
        phase = "random";
        for (int i = 0; i < 600; i++) begin
            load  = ($urandom_range(0, 15) == 0);
            value = $urandom;
            if ($urandom_range(0, 31) == 0) digit_en = 8'($urandom);
            if ($urandom_range(0, 63) == 0) lz_en = ~lz_en;
            enable = ($urandom_range(0, 149) != 0);
            cyc();
        end
        load   = 1'b0;
        enable = 1'b1;
        run(FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_seg_scan_ctrl
`default_nettype wire
